// File: rtl/hunter_input_ctrl_if.sv
// Keyboard-side bus of the hunter input controller: scan bytes and frame tick in,
// held-key state, fire pulse and hunter position out.
interface hunter_input_ctrl_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_tick;
  logic       shot_held;
  logic       left_held;
  logic       right_held;
  logic       fire_pulse;
  logic [7:0] hunter_x;
  logic       cooldown_busy;

  modport master (
    output scan_valid, scan_code, frame_tick,
    input  shot_held, left_held, right_held, fire_pulse, hunter_x, cooldown_busy
  );
  modport slave (
    input  scan_valid, scan_code, frame_tick,
    output shot_held, left_held, right_held, fire_pulse, hunter_x, cooldown_busy
  );
endinterface

// File: rtl/hunter_input_ctrl.sv
// PS/2 set-2 parser tracking fire/left/right keys; rate-limited fire pulse and saturating hunter_x.
// Optional macro HUNTER_SPACE_FIRE_EN adds space (29) as a second fire key.
module hunter_input_ctrl #(
  parameter logic [7:0] X_MIN         = 8'd4,
  parameter logic [7:0] X_MAX         = 8'd152,
  parameter logic [7:0] X_INIT        = 8'd76,
  parameter logic [7:0] STEP          = 8'd2,
  parameter logic [3:0] FIRE_COOLDOWN = 4'd8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  hunter_input_ctrl_if.slave   bus
);
  localparam logic [7:0] C_EXT   = 8'hE0;
  localparam logic [7:0] C_BRK   = 8'hF0;
  localparam logic [7:0] C_UP    = 8'h75;
  localparam logic [7:0] C_LEFT  = 8'h6B;
  localparam logic [7:0] C_RIGHT = 8'h74;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  state_e     state_q, state_d;
  logic       up_q, up_d, left_q, left_d, right_q, right_d;
  logic       shot_q, shot_d, fire_q, fire_d, busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] x_q, x_d;
  logic [8:0] x_add, x_sub;
`ifdef HUNTER_SPACE_FIRE_EN
  localparam logic [7:0] C_SPACE = 8'h29;
  logic       space_q, space_d;
`endif

  always_comb begin
    state_d = state_q;
    up_d    = up_q;
    left_d  = left_q;
    right_d = right_q;
`ifdef HUNTER_SPACE_FIRE_EN
    space_d = space_q;
`endif
    if (bus.scan_valid) begin
      if (bus.scan_code == C_EXT) begin
        state_d = EXT;
      end else if (bus.scan_code == C_BRK) begin
        state_d = (state_q == EXT || state_q == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        state_d = IDLE;
        // Final byte of a sequence: only extended codes touch the arrow keys.
        if (state_q == EXT || state_q == EXT_BRK) begin
          case (bus.scan_code)
            C_UP:    up_d    = (state_q == EXT);
            C_LEFT:  left_d  = (state_q == EXT);
            C_RIGHT: right_d = (state_q == EXT);
            default: ;
          endcase
        end
`ifdef HUNTER_SPACE_FIRE_EN
        else if (bus.scan_code == C_SPACE) begin
          space_d = (state_q == IDLE);
        end
`endif
      end
    end

`ifdef HUNTER_SPACE_FIRE_EN
    shot_d = up_d | space_d;
`else
    shot_d = up_d;
`endif
    fire_d = shot_d & ~shot_q & (cnt_q == 4'd0);

    cnt_d = cnt_q;
    if (fire_d)                              cnt_d = FIRE_COOLDOWN;
    else if (bus.frame_tick && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    busy_d = (cnt_d != 4'd0);

    // 9-bit arithmetic so underflow shows up in bit 8 instead of wrapping.
    x_add = {1'b0, x_q} + {1'b0, STEP};
    x_sub = {1'b0, x_q} - {1'b0, STEP};
    x_d   = x_q;
    if (bus.frame_tick) begin
      if (left_q && !right_q)
        x_d = (x_sub[8] || x_sub[7:0] < X_MIN) ? X_MIN : x_sub[7:0];
      else if (right_q && !left_q)
        x_d = (x_add > {1'b0, X_MAX}) ? X_MAX : x_add[7:0];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      shot_q  <= 1'b0;
      fire_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      x_q     <= X_INIT;
`ifdef HUNTER_SPACE_FIRE_EN
      space_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      left_q  <= left_d;
      right_q <= right_d;
      shot_q  <= shot_d;
      fire_q  <= fire_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
`ifdef HUNTER_SPACE_FIRE_EN
      space_q <= space_d;
`endif
    end
  end

  assign bus.shot_held     = shot_q;
  assign bus.left_held     = left_q;
  assign bus.right_held    = right_q;
  assign bus.fire_pulse    = fire_q;
  assign bus.hunter_x      = x_q;
  assign bus.cooldown_busy = busy_q;
endmodule

// File: tb/tb_hunter_input_ctrl.sv
// Directed plus random bench for hunter_input_ctrl against a prefix-flag reference model.
module tb_hunter_input_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hunter_input_ctrl_if bus();
  hunter_input_ctrl dut (.clock_i(clock), .reset_i(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;
  int fires  = 0;

  // Reference model: pending prefixes as two booleans, keys as plain bits, x as integer.
  bit m_ext, m_brk, m_up, m_left, m_right, m_space, m_fire;
  int m_x, m_cd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit v, input logic [7:0] c, input bit t);
    bit ol, orr, oshot;
    if (rst) begin
      m_ext = 0; m_brk = 0; m_up = 0; m_left = 0; m_right = 0; m_space = 0;
      m_fire = 0; m_x = 76; m_cd = 0;
      return;
    end
    ol = m_left; orr = m_right; oshot = m_up | m_space;
    if (v) begin
      if (c == 8'hE0) begin m_ext = 1; m_brk = 0; end
      else if (c == 8'hF0) m_brk = 1;
      else begin
        if (m_ext) begin
          if (c == 8'h75) m_up = !m_brk;
          if (c == 8'h6B) m_left = !m_brk;
          if (c == 8'h74) m_right = !m_brk;
        end
`ifdef HUNTER_SPACE_FIRE_EN
        else if (c == 8'h29) m_space = !m_brk;
`endif
        m_ext = 0; m_brk = 0;
      end
    end
    m_fire = (m_up | m_space) && !oshot && m_cd == 0;
    if (m_fire) m_cd = 8;
    else if (t && m_cd > 0) m_cd--;
    if (t) begin
      if (ol && !orr) m_x = (m_x - 2 < 4) ? 4 : m_x - 2;
      else if (orr && !ol) m_x = (m_x + 2 > 152) ? 152 : m_x + 2;
    end
  endtask

  task automatic cyc(input bit rst, input bit v, input logic [7:0] c, input bit t);
    reset = rst; bus.scan_valid = v; bus.scan_code = c; bus.frame_tick = t;
    @(posedge clock);
    model(rst, v, c, t);
    #1;
    if (bus.fire_pulse) fires++;
    chk("flags", {27'd0, bus.shot_held, bus.left_held, bus.right_held, bus.fire_pulse,
                  bus.cooldown_busy},
        {27'd0, m_up | m_space, m_left, m_right, m_fire, m_cd != 0});
    chk("hunter_x", {24'd0, bus.hunter_x}, m_x);
  endtask

  task automatic send(input logic [7:0] c); cyc(0, 1, c, 0); endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 1); endtask

  initial begin
    logic [7:0] pool [7];
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h74, 8'h29, 8'h1C};
    bus.scan_valid = 0; bus.scan_code = 0; bus.frame_tick = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    ticks(20);
    chk("idle_x", {24'd0, bus.hunter_x}, 32'd76);
    chk("idle_fires", fires, 0);

    send(8'hE0); send(8'h6B);
    chk("left_set", {31'd0, bus.left_held}, 1);
    ticks(5);
    chk("left_x", {24'd0, bus.hunter_x}, 32'd66);
    send(8'hE0); send(8'hF0); send(8'h6B);
    ticks(3);
    chk("left_rel_x", {24'd0, bus.hunter_x}, 32'd66);

    send(8'hE0); send(8'h74);
    ticks(50);
    chk("sat_max", {24'd0, bus.hunter_x}, 32'd152);
    send(8'hE0); send(8'h6B);
    ticks(3);
    chk("both_freeze", {24'd0, bus.hunter_x}, 32'd152);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);

    fires = 0;
    send(8'hE0); send(8'h75);
    chk("fire1", {31'd0, bus.fire_pulse}, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    ticks(3);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    ticks(5);
    send(8'hE0); send(8'h75);
    chk("fire_after_cd", {31'd0, bus.fire_pulse}, 1);
    chk("fire_count", fires, 2);
    send(8'hE0); send(8'hF0); send(8'h75);

    send(8'hE0); send(8'hF0);
    cyc(1, 0, 0, 0);
    send(8'h6B);
    chk("rst_prefix", {29'd0, bus.shot_held, bus.left_held, bus.right_held}, 0);
    send(8'hE0); send(8'hE0); send(8'h75);
    chk("ee_shot", {31'd0, bus.shot_held}, 1);
    send(8'hE0); send(8'hF0); send(8'h75);

    ticks(10);
    fires = 0;
    for (int i = 0; i < 4; i++) begin send(8'hE0); send(8'h75); end
    chk("typematic", fires, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
`ifdef HUNTER_SPACE_FIRE_EN
    ticks(10);
    fires = 0;
    send(8'h29);
    chk("space_fire", fires, 1);
    send(8'hF0); send(8'h29);
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) != 0),
          pool[$urandom_range(0, 6)], ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hunter_input_ctrl.md
Name: hunter_input_ctrl

Overview:
- Consumes the byte stream from keyboard_press_driver, parses PS/2 set-2 prefixes (E0 extended, F0 break) and tracks held state for the fire (up-arrow) and move (left/right-arrow) keys.
- Produces a rate-limited one-cycle fire pulse and a saturating hunter x-position, updated once per frame tick.
- Sits between the keyboard driver and the hunter draw logic; hunter_x feeds the hunter's draw origin.

Parameters:
- X_MIN, 8'd4, lowest legal hunter_x.
- X_MAX, 8'd152, highest legal hunter_x.
- X_INIT, 8'd76, hunter_x after reset.
- STEP, 8'd2, pixels moved per frame_tick while a direction is held.
- FIRE_COOLDOWN, 4'd8, frame_ticks that must elapse after a fire before the next fire can occur.

Ports:
- clock, in, 1, system clock (CLOCK_50 domain).
- reset, in, 1, synchronous, active-high; clears all state.
- scan_valid, in, 1, one-cycle strobe; scan_code is valid.
- scan_code, in, 8, received PS/2 byte.
- frame_tick, in, 1, one-cycle strobe per frame (frame_counter q).
- shot_held, out, 1, fire key currently down.
- left_held, out, 1, left key currently down.
- right_held, out, 1, right key currently down.
- fire_pulse, out, 1, one-cycle shot event.
- hunter_x, out, 8, hunter x-position.
- cooldown_busy, out, 1, cooldown counter is non-zero.

Behaviour:
- Clock is one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - shot_held, left_held, right_held, fire_pulse and cooldown_busy: 0.
  - hunter_x: X_INIT.
  - Cooldown counter: 0.
  - Parser state: IDLE.
- Parser FSM states are IDLE, EXT, BRK and EXT_BRK. It advances only on cycles with scan_valid=1.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - Any other byte is a non-extended make: no key change, stay in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> EXT.
  - Otherwise it is an extended make, then -> IDLE:
    - 75 sets shot.
    - 6B sets left.
    - 74 sets right.
    - Other codes are ignored.
- EXT_BRK:
  - E0 -> EXT (restart).
  - F0 -> EXT_BRK.
  - Otherwise it is an extended break, then -> IDLE: 75, 6B or 74 clears the matching held flag.
- BRK:
  - E0 -> EXT.
  - F0 -> BRK.
  - Otherwise it is a non-extended break, then -> IDLE.
- Held-flag timing: a held flag changes in the cycle after the scan_valid that carries the final byte.
- Typematic repeats (make while already held) leave the flag unchanged.
- fire_pulse:
  - Asserted for exactly one cycle, coincident with shot_held rising 0->1, when the cooldown counter is 0 at that time.
  - Otherwise the press is dropped; it is not queued.
  - Repeats and breaks never fire.
- Cooldown counter (4-bit):
  - Loaded with FIRE_COOLDOWN on a fire.
  - Otherwise decremented on frame_tick while non-zero.
  - Never wraps below 0.
  - If a fire and a frame_tick occur in the same cycle, the load wins.
- cooldown_busy = (counter != 0), registered alongside the counter.
- Movement: on frame_tick only.
  - left_held & !right_held: hunter_x <= (hunter_x - STEP < X_MIN) ? X_MIN : hunter_x - STEP.
  - right_held & !left_held: hunter_x <= (hunter_x + STEP > X_MAX) ? X_MAX : hunter_x + STEP.
  - Both or neither held: hold position.
  - Compute in 9 bits so the result never wraps.
- Movement uses the held flags registered before the current cycle; a key change in the frame_tick cycle takes effect at the next tick.
- Reset mid-prefix discards any partial E0/F0 sequence.
- A scan_valid and a frame_tick in the same cycle are both processed.

Optional Feature:
- Macro: HUNTER_SPACE_FIRE_EN.
- Defined: the non-extended code 29 (space) is a second fire key.
  - Make in IDLE sets shot; break in BRK clears it.
  - shot_held = up-arrow held OR space held; the two sources are tracked separately.
  - fire_pulse is generated on a rise of the combined shot_held.
- Undefined: 29 is ignored like any other non-extended code.

Test Plan:
- Reset, then 20 frame_ticks with no keys -> hunter_x=76 throughout; all flags 0; fire_pulse never asserted.
- Bytes E0,6B then 5 frame_ticks -> left_held=1 one cycle after 6B; hunter_x steps 74,72,70,68,66. Bytes E0,F0,6B -> left_held=0, and hunter_x stays 66 on later ticks.
- E0,74 held for 50 ticks -> hunter_x saturates at 152 without wrap. Also press left while right is held -> hunter_x frozen.
- Bytes E0,75 -> fire_pulse high exactly 1 cycle, cooldown_busy=1. Then release, press again after 3 ticks -> no pulse. Release, press again after 8 total ticks -> pulse.
- Sequence E0,F0, then reset, then 6B -> no flag change, parser back in IDLE. Also E0,E0,75 -> shot_held=1.
- Typematic: E0,75 sent 4 times with no break -> a single fire_pulse only. With HUNTER_SPACE_FIRE_EN defined, byte 29 -> fire_pulse once cooldown has expired.
